// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding, default width and counter sizing for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam int SUB_WIDTH_DEFAULT = 8;

    // Bits needed to count 0 .. value-1.
    function automatic int clog2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: d = x - y - bin, bout is the borrow into the next bit.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first, one full_sub_cell and a registered borrow.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sub_state_e       state;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             d, bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             a_msb, b_msb;
`endif

    full_sub_cell u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            brw        <= 1'b0;
            cnt        <= '0;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf        <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    brw <= bout;
                    cnt <= cnt + 1'b1;
                    // Final bit: publish the aligned result directly so diff only moves here.
                    if (cnt == LAST) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=13 instances against a cycle-schedule reference model.
module tb_serial_subtractor;

    localparam int W0 = 8;
    localparam int W1 = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [2];
    logic [15:0] av [2];
    logic [15:0] bv [2];

    logic        busy8, done8, bo8, busy13, done13, bo13;
    logic [7:0]  diff8;
    logic [12:0] diff13;

    logic        bsy [2];
    logic        dn  [2];
    logic        bov [2];
    logic [15:0] dfv [2];
    assign bsy[0] = busy8;  assign bsy[1] = busy13;
    assign dn[0]  = done8;  assign dn[1]  = done13;
    assign bov[0] = bo8;    assign bov[1] = bo13;
    assign dfv[0] = {8'b0, diff8};
    assign dfv[1] = {3'b0, diff13};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ov8, ov13;
    logic ovv [2];
    assign ovv[0] = ov8;
    assign ovv[1] = ov13;
`endif

    serial_subtractor #(.WIDTH(W0)) dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ov8)
`endif
    );

    serial_subtractor #(.WIDTH(W1)) dut13 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][12:0]), .b(bv[1][12:0]),
        .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ov13)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wof(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic logic [15:0] msk(input int k);
        return 16'((32'd1 << wof(k)) - 1);
    endfunction

    // Signed overflow from plain integer arithmetic on the two's-complement values.
    function automatic logic sovf(input int w, input logic [15:0] x, input logic [15:0] y);
        int sx, sy, r;
        sx = x[w-1] ? int'(x) - (1 << w) : int'(x);
        sy = y[w-1] ? int'(y) - (1 << w) : int'(y);
        r  = sx - sy;
        return (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
    endfunction

    // Reference model: ph=0 idle, 1..W busy, W+1 done; results committed at done.
    int          ph    [2];
    logic [15:0] pd    [2];
    logic [15:0] ed    [2];
    logic        pb    [2];
    logic        eb    [2];
    logic        po    [2];
    logic        eo    [2];
    int          ndone [2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] <= 0;
                ed[k] <= '0;
                eb[k] <= 1'b0;
                eo[k] <= 1'b0;
            end else if (ph[k] == 0) begin
                if (st[k]) begin
                    ph[k] <= 1;
                    pd[k] <= ((av[k] & msk(k)) - (bv[k] & msk(k))) & msk(k);
                    pb[k] <= (av[k] & msk(k)) < (bv[k] & msk(k));
                    po[k] <= sovf(wof(k), av[k] & msk(k), bv[k] & msk(k));
                end
            end else if (ph[k] == wof(k)) begin
                ph[k]    <= wof(k) + 1;
                ed[k]    <= pd[k];
                eb[k]    <= pb[k];
                eo[k]    <= po[k];
                ndone[k] <= ndone[k] + 1;
            end else if (ph[k] == wof(k) + 1) begin
                ph[k] <= 0;
            end else begin
                ph[k] <= ph[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("busy_w%0d", wof(k)), 16'(bsy[k]), 16'(ph[k] >= 1 && ph[k] <= wof(k)));
                check($sformatf("done_w%0d", wof(k)), 16'(dn[k]), 16'(ph[k] == wof(k) + 1));
                check($sformatf("diff_w%0d", wof(k)), dfv[k], ed[k]);
                check($sformatf("borrow_w%0d", wof(k)), 16'(bov[k]), 16'(eb[k]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check($sformatf("ovf_w%0d", wof(k)), 16'(ovv[k]), 16'(eo[k]));
`endif
            end
        end
    end

    // One 8-bit operation with literal expectations; a/b scrambled while in flight.
    task automatic op8(input string nm, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
        int n;
        @(negedge clk);
        st[0] = 1'b1; av[0] = {8'b0, x}; bv[0] = {8'b0, y};
        @(negedge clk);
        st[0] = 1'b0; av[0] = 16'($urandom); bv[0] = 16'($urandom);
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 16'(n), 16'(W0 + 1));
        check({nm, "_diff"}, {8'b0, diff8}, {8'b0, exp_d});
        check({nm, "_borrow"}, 16'(bo8), 16'(exp_b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({nm, "_ovf"}, 16'(ov8), 16'(exp_o));
`else
        if (exp_o === 1'bx) $display("unused ovf expectation");
`endif
    endtask

    initial begin
        int nd, last, d0, d1;
        st[0] = 1'b0; st[1] = 1'b0;
        av[0] = '0; av[1] = '0; bv[0] = '0; bv[1] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy8", 16'(busy8), 16'd0);
        check("rst_done8", 16'(done8), 16'd0);
        check("rst_diff8", {8'b0, diff8}, 16'd0);
        check("rst_borrow8", 16'(bo8), 16'd0);
        check("rst_diff13", {3'b0, diff13}, 16'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        op8("t200m55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
        op8("t5m10", 8'd5, 8'd10, 8'd251, 1'b1, 1'b0);
        op8("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op8("t0m0", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        op8("t0m1", 8'd0, 8'd1, 8'hFF, 1'b1, 1'b0);

        // Start held high: one accept per WIDTH+2 cycles.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 16'hFF; bv[0] = 16'h01;
        nd = 0; last = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done8) begin
                nd++;
                check("b2b_diff", {8'b0, diff8}, 16'h00FE);
                if (last >= 0) check("b2b_gap", 16'(n - last), 16'(W0 + 2));
                last = n;
            end
        end
        st[0] = 1'b0;
        check("b2b_count", 16'(nd), 16'd4);

        // Reset while bit 4 is being processed.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 16'd200; bv[0] = 16'd55;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 16'(busy8), 16'd0);
        check("abort_done", 16'(done8), 16'd0);
        check("abort_diff", {8'b0, diff8}, 16'd0);
        check("abort_borrow", 16'(bo8), 16'd0);
        op8("t3m3", 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);

        // Random sweep on both widths; inputs change every cycle.
        d0 = ndone[0]; d1 = ndone[1];
        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                st[k] = ($urandom_range(3) != 0);
                av[k] = 16'($urandom) & msk(k);
                bv[k] = 16'($urandom) & msk(k);
                if ($urandom_range(7) == 0) bv[k] = av[k];
            end
        end
        st[0] = 1'b0; st[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("sweep_ops_w8", 16'(ndone[0] - d0 >= 500), 16'd1);
        check("sweep_ops_w13", 16'(ndone[1] - d1 >= 500), 16'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor that computes a - b one bit per clock, LSB first.
- Each step uses a single-bit full-subtractor cell and a registered borrow chain.
- Sits downstream of the single-bit half-subtractor stage and extends it to multi-bit operands for the lab datapath.
- Trades area for latency: one cell, WIDTH cycles per operation.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; operands sampled when accepted
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when diff/borrow_out are valid
diff  output  WIDTH  result a - b modulo 2^WIDTH, held until next accept
borrow_out  output  1  final borrow; 1 when a < b (unsigned)

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal borrow=0, bit counter=0.
- States: IDLE, RUN, DONE (encoding from package).
- IDLE:
  - When start=1, the block loads shift registers sa<=a and sb<=b, and clears the borrow flop and the counter.
  - It then moves to RUN with busy=1 on the next cycle.
- RUN (one bit per cycle):
  - Cell inputs are sa[0], sb[0] and the borrow flop.
  - d = x^y^bin.
  - bout = (~x&y) | (~(x^y)&bin).
  - The result register shifts right with d entering at the MSB.
  - sa and sb shift right.
  - The borrow flop takes bout, and the counter increments.
  - After the cycle with counter=WIDTH-1, the block moves to DONE. The result register is then fully aligned (bit0 = LSB difference).
- DONE (exactly 1 cycle):
  - done=1, busy=0.
  - diff = result register, borrow_out = final borrow.
  - Returns to IDLE.
- Latency: start accepted at edge N, done high during cycle N+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored (not queued). start and rst asserted together: rst wins.
- diff and borrow_out hold their values after done until the next accepted start. On accept they keep their old values until the new DONE.
- rst mid-RUN: the operation is aborted immediately and all reset values apply. No done pulse is produced.
- Wrap-around: diff is always modulo 2^WIDTH. Example, WIDTH=8: 0-1 -> diff=8'hFF, borrow_out=1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset 0, updated in DONE together with diff.
  - ovf is the two's-complement signed overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using operand MSBs captured at accept.
  - Requires one extra captured bit per operand.
- Undefined: no ovf port and no extra flops. All other behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg holds:
  - state enum/localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default width constant SUB_WIDTH_DEFAULT=8
  - counter width function clog2(WIDTH)
- Sub-module full_sub_cell (inputs x, y, bin; outputs d, bout) is the natural combinational split. It is instantiated once in the datapath.

Test Plan:
- Reset, then start with a=8'd200, b=8'd55 -> done exactly 9 cycles after the accept edge; diff=8'd145, borrow_out=0.
- a=8'd5, b=8'd10 -> diff=8'd251, borrow_out=1. With OVF_EN: ovf=0.
- a=8'h80, b=8'h01 with OVF_EN -> diff=8'h7F, borrow_out=0, ovf=1. Also a=0, b=0 -> diff=0, borrow_out=0.
- Back-to-back operations:
  - Hold start=1 continuously with a=8'hFF, b=8'h01.
  - Required: a new accept only in IDLE, one accept per 10 cycles, each done gives diff=8'hFE.
  - Changing a/b while busy does not alter the in-flight result.
- Assert rst for 1 cycle during RUN at bit 4 -> no done pulse; busy/diff/borrow_out=0 next cycle. A following a=8'd3, b=8'd3 gives diff=0, borrow_out=0.
- Randomised sweep with WIDTH=8 and WIDTH=13 (at least 500 vectors each) -> diff == (a-b) mod 2^WIDTH, borrow_out == (a<b), checked against a reference model.
